// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MUL and restoring DIV.
// One op in flight; a start while busy is dropped.
module alu_multicycle #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [3:0]           Control,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   Output,
    output logic                 busy,
    output logic                 done,
    output logic                 zero,
    output logic                 err
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                           OP_SUB = 4'b0011, OP_MUL = 4'b0100, OP_MAX = 4'b0101,
                           OP_MIN = 4'b0110, OP_EQ  = 4'b0111, OP_DIV = 4'b1000;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
    state_t state, state_nx;

    logic [CW-1:0]    cnt;
    logic [W2-1:0]    acc, mcand, acc_nx;
    logic [WIDTH-1:0] mplr;
    logic [WIDTH-1:0] rem, quo, dvsr, rem_nx, quo_nx;
    logic [WIDTH:0]   rem_sh, rem_df;
    logic [WIDTH:0]   sum, dif;
    logic [W2-1:0]    sc_res;
    logic             sc_err;
    logic             accept, go_mul, go_div, last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (go_mul) state_nx = S_MUL;
                    else if (go_div) state_nx = S_DIV;
            S_MUL, S_DIV: if (last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != S_IDLE);
        accept = start && (state == S_IDLE);
        go_mul = accept && (Control == OP_MUL);
        // divide-by-zero never iterates; it completes on the single-cycle path
        go_div = accept && (Control == OP_DIV) && (B != '0);
        last   = (cnt == LAST);
    end

    always_comb begin
        sum    = {1'b0, A} + {1'b0, B};
        dif    = {1'b0, A} - {1'b0, B};
        sc_res = '0;
        sc_err = 1'b0;
        case (Control)
            OP_AND: sc_res = W2'(A & B);
            OP_OR:  sc_res = W2'(A | B);
            OP_ADD: sc_res = W2'(sum);
            OP_SUB: sc_res = W2'(dif);
            OP_MAX: sc_res = W2'((A >= B) ? A : B);
            OP_MIN: sc_res = W2'((A <= B) ? A : B);
            OP_EQ:  sc_res = W2'(A == B);
            OP_DIV: begin
                sc_res = {A, {WIDTH{1'b1}}};
                sc_err = 1'b1;
            end
            OP_MUL: sc_res = '0;
            default: sc_err = 1'b1;
        endcase
    end

    // One iteration step for each engine; the final step feeds Output directly.
    always_comb begin
        acc_nx = mplr[0] ? (acc + mcand) : acc;
        rem_sh = {rem, quo[WIDTH-1]};
        rem_df = rem_sh - {1'b0, dvsr};
        if (rem_df[WIDTH]) begin
            rem_nx = rem_sh[WIDTH-1:0];
            quo_nx = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_nx = rem_df[WIDTH-1:0];
            quo_nx = {quo[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            Output <= '0;
            done   <= 1'b0;
            zero   <= 1'b0;
            err    <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplr   <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (go_mul) begin
                    acc   <= '0;
                    mcand <= W2'(A);
                    mplr  <= B;
                    cnt   <= '0;
                end else if (go_div) begin
                    rem  <= '0;
                    quo  <= A;
                    dvsr <= B;
                    cnt  <= '0;
                end else if (accept) begin
                    Output <= sc_res;
                    zero   <= (sc_res == '0);
                    err    <= sc_err;
                    done   <= 1'b1;
                end
                S_MUL: begin
                    acc   <= acc_nx;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        Output <= acc_nx;
                        zero   <= (acc_nx == '0);
                        err    <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                S_DIV: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        Output <= {rem_nx, quo_nx};
                        zero   <= ({rem_nx, quo_nx} == '0);
                        err    <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (WIDTH=8): vector table plus multi-cycle and reset sequences.
module tb_alu_multicycle;
    localparam int W = 8;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [3:0]     Control = '0;
    logic [W-1:0]   A = '0, B = '0;
    logic [2*W-1:0] Output;
    logic           busy, done, zero, err;

    int checks = 0;
    int errors = 0;

    alu_multicycle #(.WIDTH(W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .Control(Control),
        .A(A), .B(B), .Output(Output), .busy(busy), .done(done), .zero(zero), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]     op;
        logic [W-1:0]   a, b;
        logic [2*W-1:0] out;
        logic           z, e;
    } vec_t;
    vec_t tbl[14];

    // Runs one iterative op; optionally pokes a start mid-op that must be ignored.
    task automatic mc_op(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] exp,
                         input logic ez, input bit poke);
        logic [2*W-1:0] prev;
        @(negedge clock);
        prev = Output;
        Control = op; A = a; B = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0; A = ~a; B = ~b;
        for (int i = 0; i < W; i++) begin
            chk({nm, " busy"}, busy, 1);
            chk({nm, " done_early"}, done, 0);
            chk({nm, " out_hold"}, Output, prev);
            if (poke && i == 2) begin start = 1'b1; Control = 4'b0010; end
            if (poke && i == 3) start = 1'b0;
            @(negedge clock);
        end
        chk({nm, " busy_end"}, busy, 0);
        chk({nm, " done"}, done, 1);
        chk({nm, " out"}, Output, exp);
        chk({nm, " zero"}, zero, ez);
        chk({nm, " err"}, err, 0);
    endtask

    initial begin
        int pulses;
        tbl[0]  = '{4'b0000, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0};
        tbl[1]  = '{4'b0001, 8'hF0, 8'h0F, 16'h00FF, 1'b0, 1'b0};
        tbl[2]  = '{4'b0010, 8'd200, 8'd100, 16'h012C, 1'b0, 1'b0};
        tbl[3]  = '{4'b0010, 8'd0, 8'd0, 16'h0000, 1'b1, 1'b0};
        tbl[4]  = '{4'b0011, 8'd3, 8'd5, 16'h01FE, 1'b0, 1'b0};
        tbl[5]  = '{4'b0011, 8'd5, 8'd3, 16'h0002, 1'b0, 1'b0};
        tbl[6]  = '{4'b0101, 8'd9, 8'd4, 16'h0009, 1'b0, 1'b0};
        tbl[7]  = '{4'b0110, 8'd9, 8'd4, 16'h0004, 1'b0, 1'b0};
        tbl[8]  = '{4'b0101, 8'd7, 8'd7, 16'h0007, 1'b0, 1'b0};
        tbl[9]  = '{4'b0111, 8'd7, 8'd7, 16'h0001, 1'b0, 1'b0};
        tbl[10] = '{4'b0111, 8'd7, 8'd8, 16'h0000, 1'b1, 1'b0};
        tbl[11] = '{4'b1010, 8'd3, 8'd4, 16'h0000, 1'b1, 1'b1};
        tbl[12] = '{4'b1000, 8'd5, 8'd0, 16'h05FF, 1'b0, 1'b1};
        tbl[13] = '{4'b0001, 8'h00, 8'h41, 16'h0041, 1'b0, 1'b0};

        #12;
        chk("rst out", Output, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst zero", zero, 0);
        chk("rst err", err, 0);

        // First start on the first edge after release; then one op per cycle.
        @(negedge clock);
        reset_n = 1'b1;
        Control = tbl[0].op; A = tbl[0].a; B = tbl[0].b; start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            chk($sformatf("vec%0d done", i), done, 1);
            chk($sformatf("vec%0d busy", i), busy, 0);
            chk($sformatf("vec%0d out", i), Output, tbl[i].out);
            chk($sformatf("vec%0d zero", i), zero, tbl[i].z);
            chk($sformatf("vec%0d err", i), err, tbl[i].e);
            if (i < 13) begin
                Control = tbl[i+1].op; A = tbl[i+1].a; B = tbl[i+1].b;
            end else start = 1'b0;
        end
        @(negedge clock);
        chk("done pulse one cycle", done, 0);

        mc_op("mul255", 4'b0100, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b1);
        // Start in the done cycle of MUL is accepted.
        Control = 4'b0010; A = 8'd1; B = 8'd2; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("done-cycle add done", done, 1);
        chk("done-cycle add out", Output, 16'h0003);

        mc_op("div100_7", 4'b1000, 8'd100, 8'd7, 16'h020E, 1'b0, 1'b0);
        mc_op("div255_1", 4'b1000, 8'd255, 8'd1, 16'h00FF, 1'b0, 1'b0);
        mc_op("div3_9", 4'b1000, 8'd3, 8'd9, 16'h0300, 1'b0, 1'b0);
        mc_op("mul0", 4'b0100, 8'd0, 8'd5, 16'h0000, 1'b1, 1'b0);
        mc_op("mul13_11", 4'b0100, 8'd13, 8'd11, 16'h008F, 1'b0, 1'b0);

        // Reset three cycles into a MUL aborts it.
        @(negedge clock);
        Control = 4'b0100; A = 8'd255; B = 8'd255; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("abort out", Output, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort err", err, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clock);
            if (done) pulses++;
        end
        chk("abort no done", pulses, 0);
        Control = 4'b0010; A = 8'd1; B = 8'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("post-abort add done", done, 1);
        chk("post-abort add out", Output, 16'h0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..16.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled on rising edge when busy=0.
REQ-005 Control  input  4  opcode, sampled with start.
REQ-006 A  input  WIDTH  operand A, unsigned, sampled with start.
REQ-007 B  input  WIDTH  operand B, unsigned, sampled with start.
REQ-008 Output  output  2*WIDTH  registered result; holds until next result.
REQ-009 busy  output  1  high while an iterative op is running.
REQ-010 done  output  1  one-cycle pulse; Output/zero/err valid and new.
REQ-011 zero  output  1  registered; high when new Output == 0.
REQ-012 err  output  1  registered; high on illegal opcode or divide-by-zero.

Function
REQ-013 Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 MUL, 0101 MAX, 0110 MIN, 0111 EQ, 1000 DIV; 1001-1111 illegal.
REQ-014 Operands and opcode latched into internal registers on the accepting edge; later input changes ignored until done.
REQ-015 AND/OR: low WIDTH bits = A op B, upper bits 0.
REQ-016 ADD: Output = A + B zero-extended; carry in bit WIDTH.
REQ-017 SUB: low WIDTH bits = (A - B) mod 2^WIDTH; bit WIDTH = 1 when A < B (borrow); upper bits 0.
REQ-018 MAX/MIN: low WIDTH bits = larger/smaller operand; equal operands give that value.
REQ-019 EQ: Output = 1 when A == B, else 0.
REQ-020 Single-cycle ops (AND, OR, ADD, SUB, MAX, MIN, EQ, illegal): result and done=1 registered on the accepting edge; busy stays 0.
REQ-021 MUL: iterative shift-add, one multiplier bit per cycle; full 2*WIDTH-bit product.
REQ-022 DIV: iterative restoring division, one quotient bit per cycle; Output[WIDTH-1:0] = quotient, Output[2*WIDTH-1:WIDTH] = remainder.
REQ-023 FSM states IDLE, MUL, DIV: IDLE->MUL/DIV on accepted start with opcode 0100/1000, else stay IDLE; MUL/DIV->IDLE after WIDTH iteration edges.
REQ-024 busy=1 from accepting edge until final iteration edge; done=1 and busy=0 registered on final edge; latency WIDTH cycles from accept to done.
REQ-025 Output, zero, err unchanged during MUL/DIV iterations; updated only with done.
REQ-026 start while busy=1 ignored (no queuing, no effect on running op).
REQ-027 start in the cycle done=1 accepted (busy already 0); back-to-back throughput 1/cycle for single-cycle ops.
REQ-028 DIV with B=0: no iteration; single-cycle completion, quotient all ones, remainder = A, err=1.
REQ-029 Illegal opcode: Output=0, zero=1, err=1, single-cycle.
REQ-030 err=0 for all other completions.

Reset
REQ-031 reset_n=0 forces immediately: state IDLE, Output=0, busy=0, done=0, zero=0, err=0, internal registers 0.
REQ-032 Reset during MUL/DIV aborts the op; no done pulse produced after release.
REQ-033 First start accepted on first rising edge with reset_n=1.

Verification
REQ-034 WIDTH=8: ADD A=200 B=100 -> next cycle done=1, Output=0x012C, zero=0, err=0.
REQ-035 WIDTH=8: SUB A=3 B=5 -> Output=0x01FE; EQ A=7 B=7 -> Output=1; MAX A=9 B=4 -> Output=9.
REQ-036 WIDTH=8: MUL A=255 B=255 -> busy=1 for 8 cycles, then done=1, Output=0xFE01; start pulsed mid-op ignored.
REQ-037 WIDTH=8: DIV A=100 B=7 -> after 8 cycles Output=0x020E (rem 2, quot 14); DIV A=5 B=0 -> next cycle Output=0x05FF, err=1.
REQ-038 Reset_n low 3 cycles into MUL -> outputs 0 immediately; no done after release; next ADD 1+1 -> Output=2.
REQ-039 Opcode 1010 -> Output=0, zero=1, err=1; start asserted in done cycle of MUL -> new op accepted.
